mac_seq_ctrl: RTL
=================

# mac_seq_ctrl

Sequencer for the shift-add multiplier-accumulator datapath built from the mux-select flip-flop cells. It accepts a multiply-accumulate request over a start/ready handshake and runs the product register for WIDTH iterations, adding on multiplier bit 1 and shifting on bit 0. It then commits the product to the accumulator and pulses done. It drives the 2-bit mux selects of the datapath cells directly and has no arithmetic of its own.

## Interface
- WIDTH, 8: operand width; number of shift/add iterations (2..32).
- CNT_W, 8: width of the completed-operation counter.
- CLK  in  1  clock; all state updates on rising edge.
- CLR  in  1  reset, synchronous, active-low.
- start  in  1  request one MAC; accepted only when ready=1.
- acc_clr_req  in  1  request accumulator clear; honoured only in IDLE.
- b_lsb  in  1  current multiplier LSB from the datapath.
- ready  out  1  high in IDLE only.
- busy  out  1  high from LOAD through DONE inclusive.
- prod_sel  out  2  product-register mux select: 00 hold, 01 load, 10 shift, 11 add+shift.
- acc_we  out  1  accumulator write enable (acc += product).
- acc_clr  out  1  accumulator synchronous clear pulse.
- done  out  1  one-cycle completion pulse.
- iter  out  $clog2(WIDTH+1)  current iteration index; 0 outside CALC.
- mac_count  out  CNT_W  completed MACs since last clear; saturating.

## Operation
- States: IDLE, LOAD, CALC, ACCUM, DONE.
- IDLE:
  - ready=1 and prod_sel=00.
  - acc_clr_req=1 gives acc_clr=1 that cycle (combinational on the IDLE state) and clears mac_count at the edge. The state stays IDLE.
  - start=1 with acc_clr_req=0 moves to LOAD.
  - start=1 with acc_clr_req=1: the clear wins and start is not accepted. The requester keeps start high.
- LOAD: prod_sel=01 for one cycle; iter is cleared to 0; next state is CALC.
- CALC:
  - prod_sel = b_lsb ? 11 : 10. This is the only Mealy output.
  - iter increments each cycle. When iter == WIDTH-1 the next state is ACCUM.
- ACCUM: acc_we=1 and prod_sel=00 for one cycle; next state is DONE.
- DONE:
  - done=1 and prod_sel=00.
  - mac_count increments unless it is all-ones (saturates, no wrap). Next state is IDLE.
- start and acc_clr_req are ignored while busy and are not latched.
- Reset (CLR=0 at an edge), from any state including mid-CALC:
  - state=IDLE, iter=0, mac_count=0.
  - The operation in progress is discarded and no acc_we is issued.
- Output values after reset: ready=1, busy=0, prod_sel=00, acc_we=0, acc_clr=0, done=0, iter=0, mac_count=0.

## Timing
- Edge n samples start=1 in IDLE. Then:
  - cycle n+1: LOAD.
  - cycles n+2 .. n+WIDTH+1: CALC.
  - cycle n+WIDTH+2: ACCUM (acc_we).
  - cycle n+WIDTH+3: DONE.
  - cycle n+WIDTH+4: IDLE, ready=1.
- Start-to-done latency is WIDTH+3 cycles. Back-to-back issue interval is WIDTH+4 cycles.
- The datapath presents b_lsb for the current iteration combinationally. The controller adds no register stage on b_lsb.
- All outputs except prod_sel in CALC and acc_clr in IDLE are registered-state decodes and glitch-free relative to CLK.
- mac_count is updated at the edge leaving DONE. It is visible in the first IDLE cycle.

## Structure
- Shared package mac_pkg holds:
  - the state enum (IDLE, LOAD, CALC, ACCUM, DONE);
  - the prod_sel encodings SEL_HOLD=00, SEL_LOAD=01, SEL_SHIFT=10, SEL_ADDSH=11, which the datapath mux cells also use.
- One sub-module, mac_iter_cnt, is the iteration counter with clear, enable and terminal-count output (tc when count == WIDTH-1).
- The FSM and the mac_count saturating counter stay in the top module.

## Test plan
- WIDTH=8, CLR low for 2 cycles, then start=1 for one cycle.
  - ready falls one cycle later; prod_sel=01 in the LOAD cycle.
  - Exactly 8 CALC cycles, then acc_we at cycle 10 and done at cycle 11 after start; mac_count=1.
- Multiplier pattern b_lsb=1,0,1,1,0,0,0,1 across CALC gives prod_sel = 11,10,11,11,10,10,10,11 on matching cycles.
- start and acc_clr_req both high in IDLE:
  - acc_clr=1 for one cycle, mac_count cleared, state stays IDLE.
  - start held high one more cycle is then accepted.
- CLR driven low in the 4th CALC cycle:
  - the next cycle shows IDLE, ready=1, prod_sel=00, iter=0, mac_count=0;
  - no acc_we or done is seen.
- CNT_W=2, run 5 back-to-back MACs with start held high:
  - done every 12 cycles;
  - mac_count goes 1,2,3,3,3 (saturation);
  - start during busy is never double-accepted.
- acc_clr_req pulsed mid-CALC: no acc_clr output and no effect on mac_count.

Source files
------------

// File: rtl/mac_pkg.sv
// Shared definitions for the shift-add MAC sequencer and its datapath mux cells.
// Holds the sequencer state encoding and the product-register mux select codes.
package mac_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_CALC  = 3'd2,
    ST_ACCUM = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  localparam logic [1:0] SEL_HOLD  = 2'b00;
  localparam logic [1:0] SEL_LOAD  = 2'b01;
  localparam logic [1:0] SEL_SHIFT = 2'b10;
  localparam logic [1:0] SEL_ADDSH = 2'b11;

endpackage

// File: rtl/mac_iter_cnt.sv
// Iteration counter for the MAC sequencer: counts 0..WIDTH-1 while enabled, wraps to 0 after tc.
// One-cycle update latency; no flow control, clear has priority over enable.
module mac_iter_cnt #(
  parameter int WIDTH = 8,
  parameter int IW    = $clog2(WIDTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          en,
  output logic [IW-1:0] count,
  output logic          tc
);

  assign tc = (count == IW'(WIDTH - 1));

  // Wrapping on tc keeps the count at 0 once the sequencer leaves CALC.
  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      count <= '0;
    end else if (en) begin
      count <= tc ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/mac_seq_ctrl.sv
// Sequencer for the shift-add MAC datapath: LOAD, WIDTH shift/add iterations, ACCUM, DONE.
// Start-to-done latency WIDTH+3 cycles; start is accepted only while ready, never queued.
module mac_seq_ctrl
  import mac_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8,
  localparam int IW   = $clog2(WIDTH + 1)
) (
  input  logic             CLK,
  input  logic             CLR,
  input  logic             start,
  input  logic             acc_clr_req,
  input  logic             b_lsb,
  output logic             ready,
  output logic             busy,
  output logic [1:0]       prod_sel,
  output logic             acc_we,
  output logic             acc_clr,
  output logic             done,
  output logic [IW-1:0]    iter,
  output logic [CNT_W-1:0] mac_count
);

  state_t state_q;
  state_t state_d;
  logic   iter_tc;
  logic   iter_en;

  assign iter_en = (state_q == ST_CALC);

  mac_iter_cnt #(
    .WIDTH (WIDTH),
    .IW    (IW)
  ) u_iter_cnt (
    .clk   (CLK),
    .rst_n (CLR),
    .clr   (!iter_en),
    .en    (iter_en),
    .count (iter),
    .tc    (iter_tc)
  );

  always_ff @(posedge CLK) begin
    if (!CLR) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    ready    = 1'b0;
    busy     = 1'b0;
    prod_sel = SEL_HOLD;
    acc_we   = 1'b0;
    acc_clr  = 1'b0;
    done     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        ready   = 1'b1;
        acc_clr = acc_clr_req;
        // A clear request takes the cycle; the requester keeps start asserted.
        if (start && !acc_clr_req) begin
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        busy     = 1'b1;
        prod_sel = SEL_LOAD;
        state_d  = ST_CALC;
      end
      ST_CALC: begin
        busy     = 1'b1;
        prod_sel = b_lsb ? SEL_ADDSH : SEL_SHIFT;
        if (iter_tc) begin
          state_d = ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        busy    = 1'b1;
        acc_we  = 1'b1;
        state_d = ST_DONE;
      end
      ST_DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!CLR || acc_clr) begin
      mac_count <= '0;
    end else if (state_q == ST_DONE && mac_count != {CNT_W{1'b1}}) begin
      mac_count <= mac_count + 1'b1;
    end
  end

endmodule
